// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the future transmitter.
//   parity_e         : parity mode (none / even / odd)
//   rx_state_e       : receiver FSM states
//   decode_data_bits : 2-bit config code -> data bit count (5..8)
//   decode_parity    : 2-bit config code -> parity_e (11 maps to none)
//   parity_bit       : parity bit that must accompany a data word
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned PAR_DATA_W = 8;

  function automatic logic [BIT_CNT_W-1:0] decode_data_bits(input logic [1:0] cfg);
    return 4'd5 + {2'b00, cfg};
  endfunction

  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Unused upper data bits must be zero so they do not disturb the result.
  function automatic logic parity_bit(input logic [PAR_DATA_W-1:0] data, input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word stream: valid/ready handshake carrying data plus error flags.
//   m_data  : received word, right-justified
//   m_perr  : parity error for m_data
//   m_ferr  : framing error for m_data
//   m_valid : word/flags valid
//   m_ready : consumer accepts when m_valid && m_ready
interface uart_rx_cfg_if #(
  parameter int unsigned DW = 8
) ();
  logic [DW-1:0] m_data;
  logic          m_perr;
  logic          m_ferr;
  logic          m_valid;
  logic          m_ready;

  modport master (output m_data, output m_perr, output m_ferr, output m_valid, input m_ready);
  modport slave  (input m_data, input m_perr, input m_ferr, input m_valid, output m_ready);
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
//   clk, arst_n : clock, async active-low reset (flops reset to RST_VAL)
//   d_i         : asynchronous input
//   q_o         : synchronized output, STAGES cycles of latency
module uart_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr_q <= {STAGES{RST_VAL}};
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits), oversampled on the baud-generator tick.
//   clk, arst_n        : clock, async active-low reset
//   tick               : one-cycle pulse at OVERSAMPLE x baud
//   rx                 : asynchronous serial line, idles high
//   cfg_data_bits      : 00=5 .. 11=8 data bits (latched at frame start)
//   cfg_parity         : 00/11=none, 01=even, 10=odd (latched at frame start)
//   cfg_stop2          : 1 = two stop bits (latched at frame start)
//   m                  : received-word stream (data, perr, ferr, valid/ready)
//   overrun_err        : one-cycle pulse when a completed word is dropped
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                tick,
  input  logic                rx,
  input  logic [1:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  uart_rx_cfg_if.master       m,
  output logic                overrun_err
);

  localparam int unsigned    CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  SAMPLE_PT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(OVERSAMPLE - 1);

  logic                     rxs;
  rx_state_e                state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]     bit_q, bit_d;
  logic [BIT_CNT_W-1:0]     nbits_q, nbits_d;
  parity_e                  par_q, par_d;
  logic                     stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;

  logic                     sample;
  logic                     bit_end;
  logic                     last_stop;
  logic [PAR_DATA_W-1:0]    par_data;

  logic                     commit;
  logic                     commit_perr;
  logic                     commit_ferr;

  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     mperr_q;
  logic                     mferr_q;
  logic                     valid_q;
  logic                     ovr_q;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d_i    (rx),
    .q_o    (rxs)
  );

  assign sample    = tick && (cnt_q == SAMPLE_PT);
  assign bit_end   = tick && (cnt_q == BIT_LAST);
  assign last_stop = (bit_q == {{(BIT_CNT_W-1){1'b0}}, stop2_q});
  assign par_data  = PAR_DATA_W'(shreg_q);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    if (tick) begin
      cnt_d = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) begin
          state_d = START;
          shreg_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          nbits_d = decode_data_bits(cfg_data_bits);
          par_d   = decode_parity(cfg_parity);
          stop2_d = cfg_stop2;
        end
      end

      START: begin
        if (sample && rxs) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end

      DATA: begin
        if (sample) begin
          for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            if (bit_q == BIT_CNT_W'(i)) begin
              shreg_d[i] = rxs;
            end
          end
        end
        if (bit_end) begin
          if (bit_q == nbits_q - 1'b1) begin
            bit_d   = '0;
            state_d = (par_q != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (sample && (rxs != parity_bit(par_data, par_q))) begin
          perr_d = 1'b1;
        end
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end

      STOP: begin
        if (sample) begin
          if (!rxs) begin
            ferr_d = 1'b1;
          end
          // Leave at mid last-stop so a slightly fast sender is tolerated.
          if (last_stop) begin
            state_d = rxs ? IDLE : BRK_WAIT;
          end
        end
        if (bit_end && !last_stop) begin
          bit_d = bit_q + 1'b1;
        end
      end

      BRK_WAIT: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output decode: commit strobe and the flags that go with it
  always_comb begin
    commit      = 1'b0;
    commit_perr = perr_q;
    commit_ferr = ferr_q | ~rxs;
    if ((state_q == STOP) && sample && last_stop) begin
      commit = 1'b1;
    end
  end

  // Output holding register and overrun detection
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_q  <= '0;
      mperr_q <= 1'b0;
      mferr_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit) begin
        if (!valid_q || m.m_ready) begin
          data_q  <= shreg_q;
          mperr_q <= commit_perr;
          mferr_q <= commit_ferr;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && m.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.m_data    = data_q;
  assign m.m_perr    = mperr_q;
  assign m.m_ferr    = mferr_q;
  assign m.m_valid   = valid_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg (OVERSAMPLE=16, tick every 4 clocks).
module tb_uart_rx_cfg;

  localparam int BITCLK = 64;  // 16 ticks x 4 clocks per bit

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] cfg_data_bits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       overrun_err;

  uart_rx_cfg_if #(.DW(8)) m_if ();

  uart_rx_cfg #(
    .MAX_DATA_BITS (8),
    .OVERSAMPLE    (16),
    .SYNC_STAGES   (2)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .tick          (tick),
    .rx            (rx),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .m             (m_if.master),
    .overrun_err   (overrun_err)
  );

  always #5 clk = ~clk;

  int dc = 0;
  initial begin
    forever begin
      @(negedge clk);
      tick = (dc == 3);
      dc = (dc + 1) % 4;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Stream monitor, sampled mid-cycle
  int         acc_cnt = 0;
  int         rise_cnt = 0;
  int         vcyc = 0;
  int         ovr_cnt = 0;
  int         lat_err = 0;
  logic [7:0] acc_data = '0;
  logic       acc_perr = 1'b0;
  logic       acc_ferr = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_tick = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (m_if.m_valid && m_if.m_ready) begin
        acc_cnt++;
        acc_data = m_if.m_data;
        acc_perr = m_if.m_perr;
        acc_ferr = m_if.m_ferr;
      end
      if (m_if.m_valid) vcyc++;
      if (m_if.m_valid && !prev_valid) begin
        rise_cnt++;
        if (!prev_tick) lat_err++;
      end
      if (overrun_err) ovr_cnt++;
      prev_valid = m_if.m_valid;
      prev_tick  = tick;
    end
  end

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                            input logic pb, input int ns, input logic sv);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (has_par) begin
      rx = pb;
      repeat (BITCLK) @(negedge clk);
    end
    for (int i = 0; i < ns; i++) begin
      rx = sv;
      repeat (BITCLK) @(negedge clk);
    end
  endtask

  task automatic wait_acc(input string tag, input int target);
    for (int i = 0; i < 4000 && acc_cnt < target; i++) @(negedge clk);
    check(tag, 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 4000 && !m_if.m_valid; i++) @(negedge clk);
    check(tag, 32'(m_if.m_valid), 32'd1);
  endtask

  // Raise m_ready only for the edge carrying the n-th tick after the FSM
  // enters START (3 edges after the rx fall: 2 sync flops + IDLE decode).
  task automatic ready_on_tick(input int n);
    int cnt;
    repeat (3) @(posedge clk);
    cnt = 0;
    while (cnt < n - 1) begin
      @(posedge clk);
      if (tick) cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (tick) begin
        m_if.m_ready = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    m_if.m_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
    cfg_data_bits = db;
    cfg_parity    = par;
    cfg_stop2     = s2;
  endtask

  initial begin
    int n0;
    m_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_data",  32'(m_if.m_data),  32'd0);
    check("rst_perr",  32'(m_if.m_perr),  32'd0);
    check("rst_ferr",  32'(m_if.m_ferr),  32'd0);
    check("rst_ovr",   32'(overrun_err),  32'd0);
    arst_n = 1'b1;
    m_if.m_ready = 1'b1;
    idle(2);

    // 8N1 0xA5
    set_cfg(2'b11, 2'b00, 1'b0);
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    wait_acc("a5_n", 1);
    check("a5_data", 32'(acc_data), 32'hA5);
    check("a5_perr", 32'(acc_perr), 32'd0);
    check("a5_ferr", 32'(acc_ferr), 32'd0);
    check("a5_vcyc", 32'(vcyc), 32'd1);
    check("a5_lat",  32'(lat_err), 32'd0);
    check("a5_hold", 32'(m_if.m_data), 32'hA5);
    check("a5_drop", 32'(m_if.m_valid), 32'd0);

    // 7E2 0x35, correct parity (ones=4 -> parity 0), then flipped
    set_cfg(2'b10, 2'b01, 1'b1);
    send_frame(8'h35, 7, 1, 1'b0, 2, 1'b1);
    idle(2);
    wait_acc("e7_n", 2);
    check("e7_data", 32'(acc_data), 32'h35);
    check("e7_perr", 32'(acc_perr), 32'd0);
    send_frame(8'h35, 7, 1, 1'b1, 2, 1'b1);
    idle(2);
    wait_acc("e7b_n", 3);
    check("e7b_data", 32'(acc_data), 32'h35);
    check("e7b_perr", 32'(acc_perr), 32'd1);
    check("e7b_ferr", 32'(acc_ferr), 32'd0);

    // 5O1 0x1F (ones=5 -> odd parity bit 0)
    set_cfg(2'b00, 2'b10, 1'b0);
    send_frame(8'h1F, 5, 1, 1'b0, 1, 1'b1);
    idle(2);
    wait_acc("o5_n", 4);
    check("o5_data", 32'(acc_data), 32'h1F);
    check("o5_perr", 32'(acc_perr), 32'd0);

    // Start glitch of 5 ticks, then a good 8N1 0x3C
    set_cfg(2'b11, 2'b00, 1'b0);
    n0 = rise_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(3);
    check("glitch_none", 32'(rise_cnt), 32'(n0));
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    wait_acc("g3c_n", 5);
    check("g3c_data", 32'(acc_data), 32'h3C);

    // 0x55 with bad stop and 40 bit-times of break, then 0x81
    send_frame(8'h55, 8, 0, 1'b0, 1, 1'b0);
    repeat (40 * BITCLK) @(negedge clk);
    check("brk_n",    32'(acc_cnt), 32'd6);
    check("brk_data", 32'(acc_data), 32'h55);
    check("brk_ferr", 32'(acc_ferr), 32'd1);
    idle(2);
    send_frame(8'h81, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    wait_acc("b81_n", 7);
    check("b81_data", 32'(acc_data), 32'h81);
    check("b81_ferr", 32'(acc_ferr), 32'd0);

    // Overrun: 0x11 pending, 0x22 dropped
    m_if.m_ready = 1'b0;
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    check("ov_valid", 32'(m_if.m_valid), 32'd1);
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    check("ov_keep", 32'(m_if.m_data), 32'h11);
    check("ov_pulse", 32'(ovr_cnt), 32'd1);
    m_if.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ov_acc_data", 32'(acc_data), 32'h11);
    check("ov_acc_n", 32'(acc_cnt), 32'd8);
    check("ov_drop", 32'(m_if.m_valid), 32'd0);

    // Ready exactly on the commit edge of 0x99 while 0x77 is pending
    m_if.m_ready = 1'b0;
    send_frame(8'h77, 8, 0, 1'b0, 1, 1'b1);
    idle(1);
    wait_valid("p77_valid");
    @(negedge clk);
    fork
      send_frame(8'h99, 8, 0, 1'b0, 1, 1'b1);
      ready_on_tick(16 * 9 + 8);
    join
    idle(1);
    check("cr_acc", 32'(acc_data), 32'h77);
    check("cr_data", 32'(m_if.m_data), 32'h99);
    check("cr_valid", 32'(m_if.m_valid), 32'd1);
    check("cr_ovr", 32'(ovr_cnt), 32'd1);

    // Async reset in the middle of the data bits
    fork
      send_frame(8'hF0, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (3 * BITCLK) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("mr_valid", 32'(m_if.m_valid), 32'd0);
        check("mr_data",  32'(m_if.m_data),  32'd0);
        check("mr_perr",  32'(m_if.m_perr),  32'd0);
        check("mr_ferr",  32'(m_if.m_ferr),  32'd0);
        check("mr_ovr",   32'(overrun_err),  32'd0);
      end
    join
    idle(1);
    arst_n = 1'b1;
    idle(1);
    check("mr_quiet", 32'(m_if.m_valid), 32'd0);
    m_if.m_ready = 1'b1;
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    wait_acc("mr5a_n", 10);
    check("mr5a_data", 32'(acc_data), 32'h5A);
    check("lat_all", 32'(lat_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver, the next generation of the team's fixed 8N1 receiver. It oversamples the serial line on the baud-generator tick and supports 5-8 data bits, none/even/odd parity and 1 or 2 stop bits. Each received word is delivered through a valid/ready output port together with per-word parity and framing error flags, and overrun is flagged separately. It sits between the baud-rate generator / rx pin and the RX FIFO or host register interface.

Parameters:
MAX_DATA_BITS, 8, width of the data output; the cfg_data_bits field selects 5..8 bits within it.
OVERSAMPLE, 16, ticks per bit period; must be even and at least 8.
SYNC_STAGES, 2, number of rx synchronizer flops; at least 2.

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse at OVERSAMPLE x baud, from the baud generator
rx  in  1  asynchronous serial input; idles high
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none
cfg_stop2  in  1  1 = two stop bits
m_data  out  MAX_DATA_BITS  received word, right-justified, unused upper bits 0
m_perr  out  1  parity error flag for the word in m_data
m_ferr  out  1  framing error flag for the word in m_data
m_valid  out  1  m_data/m_perr/m_ferr are valid
m_ready  in  1  consumer accepts the word when m_valid && m_ready
overrun_err  out  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset (async, arst_n low): state IDLE; synchronizer flops = 1; tick counter and bit counter = 0; m_data = 0; m_perr = m_ferr = m_valid = overrun_err = 0.
- rx passes through SYNC_STAGES flops; every FSM reference to rx below means the synchronized value rxs.
- Sample point: tick count == OVERSAMPLE/2-1 within each bit. A bit ends at count == OVERSAMPLE-1, then the count wraps to 0. Counter width is $clog2(OVERSAMPLE). The counter advances only on tick.
- cfg_* inputs are latched on leaving IDLE. Config changes mid-frame have no effect until the next frame.
- States:
  - IDLE: rxs==0 -> START, with counters cleared.
  - START: at sample point, rxs==1 -> IDLE (glitch; no output, no flag). At bit end -> DATA.
  - DATA: at sample point, shift rxs in LSB-first. After N = latched data-bit count bits -> PARITY if parity is enabled, else STOP.
  - PARITY: at sample point, compare rxs with the expected bit. Even parity: the count of ones over data+parity is even. Odd parity: that count is odd. Padding bits are excluded. Mismatch sets the pending perr.
  - STOP: sample every stop bit. Any stop sample == 0 sets the pending ferr. At the sample point of the last stop bit, commit the word. The FSM does not wait for the stop-bit end (tolerates baud mismatch): it goes to IDLE if rxs==1, else to BRK_WAIT.
  - BRK_WAIT: stay until rxs==1, then -> IDLE. A break or stuck-low line produces exactly one word with m_ferr=1.
- Commit is registered: the output updates on the clock edge after the final stop sample tick.
  - If !m_valid, or m_valid && m_ready in the same cycle: load m_data/m_perr/m_ferr and set m_valid=1.
  - Else (m_valid && !m_ready): keep the old word, drop the new one, and pulse overrun_err for 1 cycle.
- A handshake (m_valid && m_ready) without a commit clears m_valid the next cycle. m_data holds its value after m_valid drops.
- A tick absent for arbitrary cycles simply stalls the FSM; there is no timeout.
- A frame whose start glitch is rejected leaves all outputs untouched.

Decomposition:
- Shared package uart_pkg holds:
  - parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
  - rx_state_e {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}
  - a function decoding cfg_data_bits to a bit count
  - a parity-compute function shared with the future transmitter
- One sub-module, uart_sync (SYNC_STAGES flop chain, reset value parameterised to 1). It is reused by the CTS input.

Test Plan:
- 8N1 byte 0xA5, m_ready=1 -> m_valid pulses once, m_data=0xA5, m_perr=0, m_ferr=0; m_valid rises 1 clk after the stop mid-sample tick (+SYNC_STAGES latency from the rx edge).
- 7E2 word 0x35, then 7E2 with the parity bit flipped -> first m_data=0x35 with m_perr=0; second m_data=0x35 with m_perr=1. For 5O1 0x1F -> m_data=0x1F (upper 3 bits 0), m_perr=0.
- Start glitch of 5 ticks low, then high -> no m_valid. A following valid frame 0x3C is received correctly.
- 8N1 0x55 with stop bit = 0 and rx held low 40 bit-times -> exactly one word 0x55 with m_ferr=1. The FSM stays in BRK_WAIT until rx rises, then the next frame 0x81 is received.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, overrun_err pulses 1 cycle at the 0x22 commit. Then assert m_ready -> 0x11 is consumed and m_valid drops.
- m_ready asserted exactly on the commit cycle of 0x99 while 0x77 is pending -> 0x77 is consumed, m_data=0x99, m_valid stays 1, no overrun. arst_n pulsed mid-DATA -> all outputs are 0 and IDLE is reached immediately.
